// File: rtl/s3_pm_ctrl.sv
// rtl/s3_pm_ctrl.sv - S3 power-management sequencer between host and ALU
module s3_pm_ctrl #(
  parameter int IDLE_FILTER  = 4,
  parameter int SAVE_CYCLES  = 2,
  parameter int WAKE_LATENCY = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       host_a,
  input  logic [3:0]       host_b,
  input  logic [1:0]       host_opcode,
  input  logic             host_valid,
  input  logic             alu_irq,
  input  logic             wake_req,
  input  logic [3:0]       saved_a,
  input  logic [3:0]       saved_b,
  input  logic [1:0]       saved_opcode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_opcode,
  output logic             s3_state,
  output logic             alu_clk_en,
  output logic             busy,
  output logic             wake_ack,
  output logic [2:0]       pm_state,
  output logic [CNT_W-1:0] s3_count
);

  localparam int MAX_AB = (IDLE_FILTER > SAVE_CYCLES) ? IDLE_FILTER : SAVE_CYCLES;
  localparam int MAX_P  = (MAX_AB > WAKE_LATENCY) ? MAX_AB : WAKE_LATENCY;
  localparam int CW     = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    ACTIVE  = 3'd0,
    SAVE    = 3'd1,
    SLEEP   = 3'd2,
    WAKE    = 3'd3,
    RESTORE = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    idle_cnt, idle_cnt_n;
  logic [CW-1:0]    save_cnt, save_cnt_n;
  logic [CW-1:0]    wake_cnt, wake_cnt_n;
  logic             wake_pend, wake_pend_n;
  logic [3:0]       alu_a_n, alu_b_n;
  logic [1:0]       alu_opcode_n;
  logic [CNT_W-1:0] s3_count_n;

  always_comb begin
    state_n      = state;
    idle_cnt_n   = '0;
    save_cnt_n   = '0;
    wake_cnt_n   = '0;
    wake_pend_n  = 1'b0;
    alu_a_n      = alu_a;
    alu_b_n      = alu_b;
    alu_opcode_n = alu_opcode;
    s3_count_n   = s3_count;
    case (state)
      ACTIVE: begin
        if (alu_irq && !host_valid) begin
          if (idle_cnt == CW'(IDLE_FILTER - 1)) begin
            state_n = SAVE;
            if (s3_count != {CNT_W{1'b1}}) s3_count_n = s3_count + CNT_W'(1);
          end else begin
            idle_cnt_n = idle_cnt + CW'(1);
          end
        end
        // Operands freeze on the entry edge so the ALU captures the last forwarded op
        if (state_n == ACTIVE) begin
          alu_a_n      = host_a;
          alu_b_n      = host_b;
          alu_opcode_n = host_opcode;
        end
      end
      SAVE: begin
        wake_pend_n = wake_pend | wake_req;
        if (save_cnt == CW'(SAVE_CYCLES - 1)) begin
          state_n     = (wake_pend || wake_req) ? WAKE : SLEEP;
          wake_pend_n = 1'b0;
        end else begin
          save_cnt_n = save_cnt + CW'(1);
        end
      end
      SLEEP: begin
        if (wake_req) state_n = WAKE;
      end
      WAKE: begin
        if (wake_cnt == CW'(WAKE_LATENCY - 1)) begin
          state_n      = RESTORE;
          alu_a_n      = saved_a;
          alu_b_n      = saved_b;
          alu_opcode_n = saved_opcode;
        end else begin
          wake_cnt_n = wake_cnt + CW'(1);
        end
      end
      RESTORE: state_n = ACTIVE;
      default: state_n = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ACTIVE;
      idle_cnt   <= '0;
      save_cnt   <= '0;
      wake_cnt   <= '0;
      wake_pend  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      s3_state   <= 1'b0;
      alu_clk_en <= 1'b1;
      busy       <= 1'b0;
      wake_ack   <= 1'b0;
      s3_count   <= '0;
    end else begin
      state      <= state_n;
      idle_cnt   <= idle_cnt_n;
      save_cnt   <= save_cnt_n;
      wake_cnt   <= wake_cnt_n;
      wake_pend  <= wake_pend_n;
      alu_a      <= alu_a_n;
      alu_b      <= alu_b_n;
      alu_opcode <= alu_opcode_n;
      s3_state   <= (state_n == SAVE) || (state_n == SLEEP) || (state_n == WAKE);
      alu_clk_en <= (state_n != SLEEP);
      busy       <= (state_n != ACTIVE);
      wake_ack   <= (state == RESTORE);
      s3_count   <= s3_count_n;
    end
  end

  assign pm_state = state;

endmodule

// File: tb/tb_s3_pm_ctrl.sv
// tb/tb_s3_pm_ctrl.sv - directed and random check of s3_pm_ctrl against a phase model
module tb_s3_pm_ctrl;

  localparam int IDLE_FILTER  = 4;
  localparam int SAVE_CYCLES  = 2;
  localparam int WAKE_LATENCY = 8;
  localparam int CNT_MAX      = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_a, host_b, saved_a, saved_b;
  logic [1:0] host_opcode, saved_opcode;
  logic       host_valid, alu_irq, wake_req;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_opcode;
  logic       s3_state, alu_clk_en, busy, wake_ack;
  logic [2:0] pm_state;
  logic [7:0] s3_count;

  int total = 0;
  int bad   = 0;

  // model: phase numbers follow the published pm_state encoding
  int m_phase, m_run, m_rem, m_count;
  bit m_pend, m_ack;
  int m_a, m_b, m_op;

  s3_pm_ctrl #(
    .IDLE_FILTER(IDLE_FILTER), .SAVE_CYCLES(SAVE_CYCLES),
    .WAKE_LATENCY(WAKE_LATENCY), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .host_a(host_a), .host_b(host_b), .host_opcode(host_opcode), .host_valid(host_valid),
    .alu_irq(alu_irq), .wake_req(wake_req),
    .saved_a(saved_a), .saved_b(saved_b), .saved_opcode(saved_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .s3_state(s3_state), .alu_clk_en(alu_clk_en), .busy(busy), .wake_ack(wake_ack),
    .pm_state(pm_state), .s3_count(s3_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_rem = 0; m_count = 0;
    m_pend = 1'b0; m_ack = 1'b0;
    m_a = 0; m_b = 0; m_op = 0;
  endtask

  task automatic model_edge();
    m_ack = 1'b0;
    case (m_phase)
      0: begin
        m_run = (alu_irq && !host_valid) ? m_run + 1 : 0;
        if (m_run == IDLE_FILTER) begin
          m_phase = 1; m_rem = SAVE_CYCLES; m_pend = 1'b0; m_run = 0;
          if (m_count < CNT_MAX) m_count++;
        end else begin
          m_a = host_a; m_b = host_b; m_op = host_opcode;
        end
      end
      1: begin
        if (wake_req) m_pend = 1'b1;
        m_rem--;
        if (m_rem == 0) begin
          m_phase = m_pend ? 3 : 2;
          m_rem = WAKE_LATENCY;
        end
      end
      2: if (wake_req) begin m_phase = 3; m_rem = WAKE_LATENCY; end
      3: begin
        m_rem--;
        if (m_rem == 0) begin
          m_phase = 4; m_a = saved_a; m_b = saved_b; m_op = saved_opcode;
        end
      end
      default: begin m_phase = 0; m_run = 0; m_ack = 1'b1; end
    endcase
  endtask

  task automatic check_all();
    check("pm_state",   32'(pm_state),   32'(m_phase));
    check("s3_state",   32'(s3_state),   32'(m_phase >= 1 && m_phase <= 3));
    check("alu_clk_en", 32'(alu_clk_en), 32'(m_phase != 2));
    check("busy",       32'(busy),       32'(m_phase != 0));
    check("wake_ack",   32'(wake_ack),   32'(m_ack));
    check("alu_a",      32'(alu_a),      32'(m_a));
    check("alu_b",      32'(alu_b),      32'(m_b));
    check("alu_opcode", 32'(alu_opcode), 32'(m_op));
    check("s3_count",   32'(s3_count),   32'(m_count));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // asserted between edges: outputs must change without waiting for a clock
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    host_a = 4'd9; host_b = 4'd6; host_opcode = 2'b10; host_valid = 1'b0;
    alu_irq = 1'b0; wake_req = 1'b0;
    saved_a = 4'd0; saved_b = 4'd0; saved_opcode = 2'b00;
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b0;
    steps(2);

    // entry from a zero operand after four idle cycles
    host_a = 4'd0; host_b = 4'd0; host_opcode = 2'b00; alu_irq = 1'b1;
    steps(1);
    steps(IDLE_FILTER);
    check("entry_pm", 32'(pm_state), 32'd1);
    steps(SAVE_CYCLES);
    check("sleep_pm", 32'(pm_state), 32'd2);
    alu_irq = 1'b0;
    steps(3);

    // full wake with host traffic discarded during the ramp
    saved_a = 4'd5; saved_b = 4'd3; saved_opcode = 2'b01;
    wake_req = 1'b1;
    steps(1);
    wake_req = 1'b0;
    for (int i = 0; i < WAKE_LATENCY; i++) begin
      host_valid = 1'b1;
      host_a = 4'($urandom); host_b = 4'($urandom); host_opcode = 2'($urandom);
      step();
    end
    host_valid = 1'b0;
    check("restore_pm", 32'(pm_state), 32'd4);
    check("restore_sub", 32'((alu_a - alu_b) & 4'hf), 32'd2);
    steps(1);
    check("wake_ack_pulse", 32'(wake_ack), 32'd1);
    steps(2);

    // idle filter cancelled by host traffic and by an irq drop
    alu_irq = 1'b1;
    steps(3);
    host_valid = 1'b1;
    steps(1);
    host_valid = 1'b0;
    steps(3);
    alu_irq = 1'b0;
    steps(1);
    alu_irq = 1'b1;
    steps(2);
    alu_irq = 1'b0;
    steps(1);
    alu_irq = 1'b1;
    steps(3);
    alu_irq = 1'b0;
    steps(1);
    check("cancel_count", 32'(s3_count), 32'd1);

    // early wake during the first SAVE cycle skips SLEEP
    alu_irq = 1'b1;
    steps(IDLE_FILTER);
    alu_irq = 1'b0;
    wake_req = 1'b1;
    steps(1);
    wake_req = 1'b0;
    steps(SAVE_CYCLES - 1);
    check("early_wake_pm", 32'(pm_state), 32'd3);
    steps(WAKE_LATENCY + 2);

    // reset during WAKE returns to ACTIVE with no replay
    alu_irq = 1'b1;
    steps(IDLE_FILTER);
    alu_irq = 1'b0;
    wake_req = 1'b1;
    steps(SAVE_CYCLES + 3);
    wake_req = 1'b0;
    do_reset();
    steps(WAKE_LATENCY + 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      host_a = 4'($urandom); host_b = 4'($urandom); host_opcode = 2'($urandom);
      saved_a = 4'($urandom); saved_b = 4'($urandom); saved_opcode = 2'($urandom);
      alu_irq = ($urandom_range(0, 9) != 0);
      host_valid = ($urandom_range(0, 15) == 0);
      wake_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    // saturation of the entry counter
    do_reset();
    alu_irq = 1'b1; host_valid = 1'b0; wake_req = 1'b1;
    for (int i = 0; i < 6000 && m_count < CNT_MAX; i++) step();
    check("sat_reached", 32'(s3_count), 32'd255);
    steps(3 * (IDLE_FILTER + SAVE_CYCLES + WAKE_LATENCY + 1));
    check("sat_held", 32'(s3_count), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s3_pm_ctrl.md
Name: s3_pm_ctrl

Overview:
- Power-management sequencer that drives the ALU's S3 signal and consumes its idle interrupt.
- In ACTIVE, forwards host operands to the ALU; sustained idle interrupt → commands S3 entry (ALU captures saved_a/saved_b/saved_opcode), gates the ALU, sleeps until wake.
- On wake, waits out power ramp, then replays the saved operation from the ALU's saved_* outputs before returning control to the host.
- Sits between host/top-level and the ALU.

Parameters:
- IDLE_FILTER, 4, consecutive cycles of interrupt=1 required before S3 entry (≥1)
- SAVE_CYCLES, 2, cycles s3_state held in SAVE before SLEEP (≥1)
- WAKE_LATENCY, 8, power-ramp cycles in WAKE (≥1)
- CNT_W, 8, width of saturating S3-entry counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- host_a  in  4  host operand 1
- host_b  in  4  host operand 2
- host_opcode  in  2  host opcode (00 ADD, 01 SUB, 10 AND, 11 OR)
- host_valid  in  1  host presenting a new operation this cycle
- alu_irq  in  1  ALU idle interrupt
- wake_req  in  1  wake request (level, sampled)
- saved_a  in  4  ALU saved operand 1
- saved_b  in  4  ALU saved operand 2
- saved_opcode  in  2  ALU saved opcode
- alu_a  out  4  operand to ALU
- alu_b  out  4  operand to ALU
- alu_opcode  out  2  opcode to ALU
- s3_state  out  1  S3 command to ALU
- alu_clk_en  out  1  ALU clock-gate enable
- busy  out  1  1 when state≠ACTIVE; host ops dropped
- wake_ack  out  1  one-cycle pulse on RESTORE→ACTIVE
- pm_state  out  3  ACTIVE=0, SAVE=1, SLEEP=2, WAKE=3, RESTORE=4
- s3_count  out  CNT_W  number of S3 entries, saturating

Behaviour:
- All outputs registered.
- Reset (async, any state) → ACTIVE; alu_a=0, alu_b=0, alu_opcode=00, s3_state=0, alu_clk_en=1, busy=0, wake_ack=0, s3_count=0, all internal counters=0, wake-pending=0.
- ACTIVE:
  - alu_* ← host_* each cycle.
  - idle_cnt increments while alu_irq=1 and host_valid=0; clears otherwise.
  - When idle_cnt reaches IDLE_FILTER-1 with alu_irq=1 and host_valid=0 → SAVE next cycle; s3_count += 1, saturating at all-ones.
  - host_valid=1 on the trigger cycle cancels entry.
- SAVE:
  - s3_state=1, alu_clk_en=1.
  - alu_* frozen at the values driven on the last ACTIVE cycle (ALU captures them).
  - Exactly SAVE_CYCLES cycles, then → SLEEP.
  - wake_req=1 during SAVE sets wake-pending. After SAVE completes, wake-pending → WAKE (SLEEP skipped, but save still completes).
- SLEEP:
  - s3_state=1, alu_clk_en=0, alu_* held.
  - wake_req=1 → WAKE next cycle.
- WAKE:
  - s3_state=1, alu_clk_en=1.
  - Exactly WAKE_LATENCY cycles, then → RESTORE.
  - wake_req ignored.
- RESTORE:
  - One cycle. s3_state=0; alu_a/alu_b/alu_opcode ← saved_a/saved_b/saved_opcode (registered on WAKE→RESTORE edge).
  - ALU recomputes the saved result.
  - Next state ACTIVE with wake_ack=1 for that first ACTIVE cycle; idle_cnt=0.
- busy=1 in every state except ACTIVE; host_valid while busy is discarded, no queuing.
- Counters: idle_cnt, save_cnt, wake_cnt are sized ceil(log2(max param))+1, reset on every state entry, no wrap.
- Reset mid-SAVE/SLEEP/WAKE: immediate ACTIVE; saved operation is not replayed.

Test Plan:
- Reset: assert reset mid-cycle → all outputs at reset values immediately; pm_state=0, alu_clk_en=1.
- Entry: host_a=0, host_b=0, op=00, alu_irq=1 held 4 cycles → pm_state 1 for 2 cycles, s3_state=1, alu_a=0, s3_count=1; then pm_state=2, alu_clk_en=0.
- Full wake: in SLEEP with saved_a=5, saved_b=3, saved_opcode=01, pulse wake_req → 8 cycles WAKE, then RESTORE with alu_a=5, alu_b=3, alu_opcode=01, s3_state=0, ALU result=2; next cycle wake_ack=1, pm_state=0.
- Filter cancel: alu_irq=1 for 3 cycles then host_valid=1 → stays ACTIVE, s3_count unchanged; alu_irq dropping after 2 cycles also resets idle_cnt.
- Early wake: wake_req=1 on first SAVE cycle → SAVE lasts 2 cycles, then pm_state goes directly to 3; SLEEP never entered.
- Saturation/busy: force 255 entries with CNT_W=8 → s3_count stays 255 on the 256th; host_valid during WAKE → alu_* unchanged, busy=1.
